// File: rtl/seg_bank_arbiter.sv
// seg_bank_arbiter: round-robin owner of the 8-digit seven-segment bank with a minimum hold quantum.
// Optional macro SEG_ARB_OWNER_DP_EN lights the dp of digit seg<own> while an owner holds the bank.
module seg_bank_arbiter #(
    parameter int NREQ    = 3,
    parameter int QUANTUM = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*32-1:0] data,
    input  logic [NREQ*8-1:0]  blank,
    output logic [NREQ-1:0]    gnt,
    output logic               busy,
    output logic [7:0]         seg0,
    output logic [7:0]         seg1,
    output logic [7:0]         seg2,
    output logic [7:0]         seg3,
    output logic [7:0]         seg4,
    output logic [7:0]         seg5,
    output logic [7:0]         seg6,
    output logic [7:0]         seg7
);
    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(QUANTUM + 1);
    typedef enum logic {IDLE, OWN} state_t;
    state_t          state_q, state_d;
    logic [PW-1:0]   own_q, own_d, ptr_q, ptr_d, pick, own_next;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [7:0]      seg_q [8];
    logic [7:0]      seg_d [8];
    logic [31:0]     own_data;
    logic [7:0]      own_blank;
    logic            found, others;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    assign others   = |(req & ~(NREQ'(1) << own_q));
    assign own_next = (int'(own_q) == NREQ - 1) ? '0 : own_q + PW'(1);

    // Live nibbles and blank mask of the current owner
    always_comb begin
        own_data  = '0;
        own_blank = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (int'(own_q) == i) begin
                own_data  = data[32*i +: 32];
                own_blank = blank[8*i +: 8];
            end
        end
    end

    // First requester found scanning from ptr with wraparound
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < NREQ; i++) begin
            logic [PW-1:0] idx;
            idx = PW'((int'(ptr_q) + i) % NREQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Ownership state machine: grant from IDLE, release or preempt from OWN
    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        if (state_q == IDLE) begin
            state_d = found ? OWN : IDLE;
            own_d   = found ? pick : own_q;
            cnt_d   = found ? CW'(1) : cnt_q;
            gnt_d   = found ? NREQ'(1) << pick : '0;
        end else if (!req[own_q] || (cnt_q >= CW'(QUANTUM) && others)) begin
            state_d = IDLE;
            ptr_d   = own_next;
            cnt_d   = '0;
            gnt_d   = '0;
        end else begin
            cnt_d   = (cnt_q >= CW'(QUANTUM)) ? cnt_q : cnt_q + CW'(1);
        end
    end

    // Segment decode of the owner's data, blanked when no owner or masked
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            seg_d[k] = (|gnt_q && !own_blank[k]) ? {1'b1, hex7(own_data[4*k +: 4])} : 8'hFF;
`ifdef SEG_ARB_OWNER_DP_EN
            if (|gnt_q && int'(own_q) == k) seg_d[k][7] = 1'b0;
`endif
        end
    end

    // State and output registers, cleared asynchronously by active-low rst
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            own_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            for (int k = 0; k < 8; k++) seg_q[k] <= 8'hFF;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            for (int k = 0; k < 8; k++) seg_q[k] <= seg_d[k];
        end
    end

    assign gnt  = gnt_q;
    assign busy = |gnt_q;
    assign seg0 = seg_q[0];
    assign seg1 = seg_q[1];
    assign seg2 = seg_q[2];
    assign seg3 = seg_q[3];
    assign seg4 = seg_q[4];
    assign seg5 = seg_q[5];
    assign seg6 = seg_q[6];
    assign seg7 = seg_q[7];
endmodule

// File: tb/tb_seg_bank_arbiter.sv
// tb_seg_bank_arbiter: randomized scoreboard bench for seg_bank_arbiter against a behavioural model.
module tb_seg_bank_arbiter;
    localparam int N = 3;
    localparam int Q = 4;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*32-1:0] data = '0;
    logic [N*8-1:0]  blank = '0;
    logic [N-1:0]    gnt;
    logic            busy;
    logic [7:0]      seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7;

    seg_bank_arbiter #(.NREQ(N), .QUANTUM(Q)) dut (
        .clk(clk), .rst(rst), .req(req), .data(data), .blank(blank),
        .gnt(gnt), .busy(busy),
        .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3),
        .seg4(seg4), .seg5(seg5), .seg6(seg6), .seg7(seg7)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] g;
        logic [63:0]  s;
    } exp_t;
    exp_t q[$];
    int n_vec = 0;
    int n_err = 0;
    int m_own = -1;
    int m_cnt = 0;
    int m_ptr = 0;
    logic [7:0] hex_tab [16];

    initial hex_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] exp_seg();
        logic [63:0] s;
        s = '1;
        if (m_own >= 0) begin
            for (int k = 0; k < 8; k++) begin
                logic [3:0] nib;
                nib = data[32*m_own + 4*k +: 4];
                if (!blank[8*m_own + k]) s[8*k +: 8] = hex_tab[nib];
`ifdef SEG_ARB_OWNER_DP_EN
                if (k == m_own) s[8*k + 7] = 1'b0;
`endif
            end
        end
        return s;
    endfunction

    task automatic step(input logic r, input logic [N-1:0] rq, input logic [N*32-1:0] d, input logic [N*8-1:0] bl);
        exp_t e;
        @(negedge clk);
        rst = r; req = rq; data = d; blank = bl;
        if (!r) begin
            #1;
            chk("rst_gnt", 64'(gnt), 64'(0));
            chk("rst_busy", 64'(busy), 64'(0));
            chk("rst_seg", {seg7, seg6, seg5, seg4, seg3, seg2, seg1, seg0}, '1);
            m_own = -1; m_cnt = 0; m_ptr = 0;
            e.g = '0;
            e.s = '1;
        end else begin
            e.s = exp_seg();
            if (m_own < 0) begin
                for (int i = 0; i < N; i++) begin
                    if (m_own < 0 && req[(m_ptr + i) % N]) begin
                        m_own = (m_ptr + i) % N;
                        m_cnt = 1;
                    end
                end
            end else if (!req[m_own] || (m_cnt >= Q && (req & ~(N'(1) << m_own)) != 0)) begin
                m_ptr = (m_own + 1) % N;
                m_own = -1;
            end else if (m_cnt < Q) begin
                m_cnt++;
            end
            e.g = (m_own < 0) ? '0 : N'(1) << m_own;
        end
        q.push_back(e);
    endtask

    function automatic logic [N*32-1:0] rdata();
        return {$urandom, $urandom, $urandom};
    endfunction

    function automatic logic [N*8-1:0] rblank();
        return N*8'($urandom & $urandom & $urandom);
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("gnt", 64'(gnt), 64'(e.g));
                chk("busy", 64'(busy), 64'(|e.g));
                chk("seg", {seg7, seg6, seg5, seg4, seg3, seg2, seg1, seg0}, e.s);
            end
        end
    end

    initial begin
        logic [N-1:0] rq;
        repeat (5) step(1'b0, N'($urandom), rdata(), rblank());
        repeat (3) step(1'b1, '0, rdata(), rblank());
        repeat (3) step(1'b1, 3'b001, {64'h0, 32'h0123_4567}, '0);
        repeat (2) step(1'b1, 3'b001, {64'h0, 32'h0123_4567}, 24'h80);
        step(1'b1, '0, rdata(), '0);
        repeat (3 * (Q + 1) + 2) step(1'b1, 3'b011, rdata(), '0);
        repeat (2) step(1'b1, 3'b110, rdata(), rblank());
        repeat (4) step(1'b1, 3'b100, rdata(), rblank());
        step(1'b0, 3'b111, rdata(), '0);
        repeat (4 * (Q + 1)) step(1'b1, 3'b111, rdata(), 24'h04_0000);
        step(1'b0, 3'b111, rdata(), '0);
        repeat (3) step(1'b1, 3'b101, rdata(), 24'h04_0000);
        rq = '0;
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < N; b++) if ($urandom_range(0, 11) == 0) rq[b] = ~rq[b];
            step(($urandom_range(0, 599) != 0), rq, rdata(), rblank());
        end
        repeat (2) @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
